// File: rtl/counter_stim_seq.sv
// -----------------------------------------------------------------------------
// counter_stim_seq
//
// Synthesizable stimulus sequencer for the up/down counter DUT. It drives the
// counter's enable / reset / mode / D inputs through a fixed, repeatable
// exercise pattern so that a self-checking run needs no behavioural stimulus.
// A checker watching the same signals runs in parallel.
//
// One run = one DUT reset (2 cycles), then ITERATIONS passes of:
//   LOAD (1) -> UP (PHASE_LEN) -> DN1 (PHASE_LEN) -> DN3 (PHASE_LEN) -> DIS (2)
// The load value starts at SEED and advances by D <- 5*D + 3 (mod 2^WIDTH)
// between passes.
//
// Parameters:
//   WIDTH       width of D
//   PHASE_LEN   cycles per counting phase (>= 1)
//   ITERATIONS  passes per run (>= 1)
//   SEED        first load value, truncated to WIDTH
//   CARGA_D, CUENTA_MAS_UNO, CUENTA_MENOS_UNO, CUENTA_TRES_TRES
//               mode encodings; override to match the shared defines.v macros
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   begins a run when sampled high in IDLE or DONE
//   abort      in   synchronous return to IDLE; wins over start
//   enable     out  DUT enable
//   reset_cnt  out  DUT reset, active-high
//   mode       out  DUT mode
//   D          out  DUT load value
//   busy       out  high while a run is in progress
//   done       out  high in DONE
//   iter       out  current pass index, 0-based
// -----------------------------------------------------------------------------
module counter_stim_seq #(
    parameter int         WIDTH            = 4,
    parameter int         PHASE_LEN        = 8,
    parameter int         ITERATIONS       = 4,
    parameter int         SEED             = 0,
    parameter logic [1:0] CUENTA_MAS_UNO   = 2'b00,
    parameter logic [1:0] CUENTA_MENOS_UNO = 2'b01,
    parameter logic [1:0] CUENTA_TRES_TRES = 2'b10,
    parameter logic [1:0] CARGA_D          = 2'b11
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    output logic                              enable,
    output logic                              reset_cnt,
    output logic [1:0]                        mode,
    output logic [WIDTH-1:0]                  D,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(ITERATIONS+1)-1:0]   iter
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int PH_W = $clog2(PHASE_LEN + 1);
    localparam int IT_W = $clog2(ITERATIONS + 1);

    // The phase counter holds "cycles remaining minus one" for the current
    // state, so a phase expires when it reads zero.
    localparam logic [PH_W-1:0] PH_LAST_COUNT = PH_W'(PHASE_LEN - 1);
    localparam logic [PH_W-1:0] PH_LAST_TWO   = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST_ONE   = '0;
    localparam logic [PH_W-1:0] PH_ONE        = PH_W'(1);

    localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(ITERATIONS - 1);
    localparam logic [IT_W-1:0]  ITER_ONE  = IT_W'(1);
    localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] LCG_INC   = WIDTH'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_UP,
        S_DN1,
        S_DN3,
        S_DIS,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic [PH_W-1:0]   phase_cnt;
    logic [PH_W-1:0]   phase_nxt;
    logic              phase_expired;

    logic              enable_nxt;
    logic              reset_cnt_nxt;
    logic [1:0]        mode_nxt;
    logic [WIDTH-1:0]  d_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic [IT_W-1:0]   iter_nxt;
    logic [WIDTH-1:0]  d_lcg;

    assign phase_expired = (phase_cnt == '0);

    // 5*D + 3 as shift-and-add; the sum wraps naturally at WIDTH bits.
    assign d_lcg = (D << 2) + D + LCG_INC;

    // -------------------------------------------------------------------------
    // Next-state, phase counter, pass index and load value
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that paths that
        // do not assign it hold their value instead of inferring a latch.
        state_nxt = state;
        phase_nxt = phase_cnt;
        iter_nxt  = iter;
        d_nxt     = D;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_RST;
                    phase_nxt = PH_LAST_TWO;
                    iter_nxt  = '0;
                    d_nxt     = SEED_W;
                end
            end

            S_RST: begin
                if (phase_expired) begin
                    state_nxt = S_LOAD;
                    phase_nxt = PH_LAST_ONE;
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            S_LOAD: begin
                if (phase_expired) begin
                    state_nxt = S_UP;
                    phase_nxt = PH_LAST_COUNT;
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            S_UP: begin
                if (phase_expired) begin
                    state_nxt = S_DN1;
                    phase_nxt = PH_LAST_COUNT;
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            S_DN1: begin
                if (phase_expired) begin
                    state_nxt = S_DN3;
                    phase_nxt = PH_LAST_COUNT;
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            S_DN3: begin
                if (phase_expired) begin
                    state_nxt = S_DIS;
                    phase_nxt = PH_LAST_TWO;
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            S_DIS: begin
                if (phase_expired) begin
                    phase_nxt = '0;
                    if (iter < ITER_LAST) begin
                        state_nxt = S_LOAD;
                        iter_nxt  = iter + ITER_ONE;
                        d_nxt     = d_lcg;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    phase_nxt = phase_cnt - PH_ONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
            end
        endcase

        // Abort overrides any transition above, including a start in the same
        // cycle; pass index and load value stay put until the next start.
        if (abort) begin
            state_nxt = S_IDLE;
            phase_nxt = '0;
            iter_nxt  = iter;
            d_nxt     = D;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state. Outputs are registered together with
    // the state, so they change on the same edge as the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        enable_nxt    = 1'b0;
        reset_cnt_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        mode_nxt      = mode;     // mode is held in IDLE, RST, DIS and DONE

        case (state_nxt)
            S_RST: begin
                reset_cnt_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
            S_LOAD: begin
                enable_nxt = 1'b1;
                mode_nxt   = CARGA_D;
                busy_nxt   = 1'b1;
            end
            S_UP: begin
                enable_nxt = 1'b1;
                mode_nxt   = CUENTA_MAS_UNO;
                busy_nxt   = 1'b1;
            end
            S_DN1: begin
                enable_nxt = 1'b1;
                mode_nxt   = CUENTA_MENOS_UNO;
                busy_nxt   = 1'b1;
            end
            S_DN3: begin
                enable_nxt = 1'b1;
                mode_nxt   = CUENTA_TRES_TRES;
                busy_nxt   = 1'b1;
            end
            S_DIS: begin
                busy_nxt = 1'b1;
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                // IDLE: everything low, mode held
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            enable    <= 1'b0;
            reset_cnt <= 1'b0;
            mode      <= 2'b00;
            D         <= SEED_W;
            busy      <= 1'b0;
            done      <= 1'b0;
            iter      <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            enable    <= enable_nxt;
            reset_cnt <= reset_cnt_nxt;
            mode      <= mode_nxt;
            D         <= d_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            iter      <= iter_nxt;
        end
    end

endmodule

// File: tb/tb_counter_stim_seq.sv
// -----------------------------------------------------------------------------
// tb_counter_stim_seq
//
// Directed bench for counter_stim_seq. Two instances share the clock:
//   u_dut   default build  (WIDTH=4,  PHASE_LEN=8, ITERATIONS=4, SEED=0)
//   u_wide  wide build     (WIDTH=32, PHASE_LEN=1, ITERATIONS=2, SEED=0)
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point. "k" is the number of edges since the start edge E0.
// -----------------------------------------------------------------------------
module tb_counter_stim_seq;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DN1  = 2'b01;
    localparam logic [1:0] M_DN3  = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    typedef struct packed {
        logic        en;
        logic        rc;
        logic [1:0]  mode;
        logic        busy;
        logic        done;
        logic [2:0]  iter;
        logic [31:0] d;
    } obs_t;

    logic clk;

    // default build
    logic       n_reset, n_start, n_abort;
    logic       n_enable, n_reset_cnt, n_busy, n_done;
    logic [1:0] n_mode;
    logic [3:0] n_d;
    logic [2:0] n_iter;

    // wide build
    logic        w_reset, w_start, w_abort;
    logic        w_enable, w_reset_cnt, w_busy, w_done;
    logic [1:0]  w_mode;
    logic [31:0] w_d;
    logic [1:0]  w_iter;

    int checks = 0;
    int errors = 0;

    counter_stim_seq #(
        .WIDTH(4), .PHASE_LEN(8), .ITERATIONS(4), .SEED(0),
        .CUENTA_MAS_UNO(M_UP), .CUENTA_MENOS_UNO(M_DN1),
        .CUENTA_TRES_TRES(M_DN3), .CARGA_D(M_LOAD)
    ) u_dut (
        .clk(clk), .reset(n_reset), .start(n_start), .abort(n_abort),
        .enable(n_enable), .reset_cnt(n_reset_cnt), .mode(n_mode), .D(n_d),
        .busy(n_busy), .done(n_done), .iter(n_iter)
    );

    counter_stim_seq #(
        .WIDTH(32), .PHASE_LEN(1), .ITERATIONS(2), .SEED(0),
        .CUENTA_MAS_UNO(M_UP), .CUENTA_MENOS_UNO(M_DN1),
        .CUENTA_TRES_TRES(M_DN3), .CARGA_D(M_LOAD)
    ) u_wide (
        .clk(clk), .reset(w_reset), .start(w_start), .abort(w_abort),
        .enable(w_enable), .reset_cnt(w_reset_cnt), .mode(w_mode), .D(w_d),
        .busy(w_busy), .done(w_done), .iter(w_iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample_n();
        obs_t o;
        o      = '0;
        o.en   = n_enable;
        o.rc   = n_reset_cnt;
        o.mode = n_mode;
        o.busy = n_busy;
        o.done = n_done;
        o.iter = n_iter;
        o.d    = {28'd0, n_d};
        return o;
    endfunction

    function automatic obs_t sample_w();
        obs_t o;
        o      = '0;
        o.en   = w_enable;
        o.rc   = w_reset_cnt;
        o.mode = w_mode;
        o.busy = w_busy;
        o.done = w_done;
        o.iter = {1'b0, w_iter};
        o.d    = w_d;
        return o;
    endfunction

    // Hand-computed load values: 4-bit 0,3,2,13 ; 32-bit 0,3
    function automatic logic [31:0] d_seq(int p, bit narrow);
        if (narrow) begin
            case (p)
                0:       return 32'd0;
                1:       return 32'd3;
                2:       return 32'd2;
                default: return 32'd13;
            endcase
        end else begin
            return (p == 0) ? 32'd0 : 32'd3;
        end
    endfunction

    // Expected outputs after edge Ek of a run started at E0 with SEED=0.
    // mode0 is whatever mode was showing before the run (held through RST).
    function automatic obs_t exp_obs(int k, int pl, int its, logic [1:0] mode0, bit narrow);
        obs_t e;
        int   plen;
        int   p;
        int   o;
        e    = '0;
        plen = 3 * pl + 3;
        if (k < 2) begin
            e.rc   = 1'b1;
            e.busy = 1'b1;
            e.mode = mode0;
        end else if (k < 2 + its * plen) begin
            p      = (k - 2) / plen;
            o      = (k - 2) % plen;
            e.busy = 1'b1;
            e.iter = 3'(p);
            e.d    = d_seq(p, narrow);
            if (o == 0) begin
                e.en = 1'b1; e.mode = M_LOAD;
            end else if (o <= pl) begin
                e.en = 1'b1; e.mode = M_UP;
            end else if (o <= 2 * pl) begin
                e.en = 1'b1; e.mode = M_DN1;
            end else if (o <= 3 * pl) begin
                e.en = 1'b1; e.mode = M_DN3;
            end else begin
                e.mode = M_DN3;   // DIS: enable low, mode held
            end
        end else begin
            e.done = 1'b1;
            e.mode = M_DN3;
            e.iter = 3'(its - 1);
            e.d    = d_seq(its - 1, narrow);
        end
        return e;
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        obs_t got;
        obs_t exp_n;
        exp_n   = '0;
        n_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = sample_n();
            checks++;
            if (got !== exp_n) begin
                errors++;
                $display("FAIL reset edge=%0d got=%h exp=%h", i, got, exp_n);
            end
        end
        got = sample_w();
        checks++;
        if (got !== exp_n) begin
            errors++;
            $display("FAIL reset_wide got=%h exp=%h", got, exp_n);
        end
        n_reset = 1'b1;
        n_start = 1'b0;
        w_reset = 1'b1;
        step();
        got = sample_n();
        checks++;
        if (got !== exp_n) begin
            errors++;
            $display("FAIL reset_release_idle got=%h exp=%h", got, exp_n);
        end
    endtask

    task automatic test_default_run();
        obs_t got;
        obs_t exp_v;
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        for (int k = 0; k <= 112; k++) begin
            if (k > 0) step();
            got   = sample_n();
            exp_v = exp_obs(k, 8, 4, 2'b00, 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL default_run k=%0d got=%h exp=%h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_start_while_busy();
        obs_t got;
        obs_t exp_v;
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        for (int k = 0; k <= 112; k++) begin
            if (k > 0) step();
            got   = sample_n();
            exp_v = exp_obs(k, 8, 4, M_DN3, 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL start_while_busy k=%0d got=%h exp=%h", k, got, exp_v);
            end
            n_start = (k == 19);   // start is high at edge E20
        end
        n_start = 1'b0;
    endtask

    task automatic test_restart_from_done();
        obs_t got;
        obs_t exp_v;
        checks++;
        if (n_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_precond done=%b exp=1", n_done);
        end
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        for (int k = 0; k <= 111; k++) begin
            if (k > 0) step();
            got   = sample_n();
            exp_v = exp_obs(k, 8, 4, M_DN3, 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL restart_from_done k=%0d got=%h exp=%h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        obs_t got;
        obs_t exp_v;
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        for (int k = 0; k <= 39; k++) begin
            if (k > 0) step();
            got   = sample_n();
            exp_v = exp_obs(k, 8, 4, M_DN3, 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL abort_prefix k=%0d got=%h exp=%h", k, got, exp_v);
            end
        end
        // abort and start together at E40 (mid-DN1 of pass 1)
        n_abort = 1'b1;
        n_start = 1'b1;
        step();
        n_abort = 1'b0;
        n_start = 1'b0;
        exp_v      = '0;
        exp_v.mode = M_DN1;
        exp_v.iter = 3'd1;
        exp_v.d    = 32'd3;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) step();
            got = sample_n();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        // rerun from RST with D back at SEED; left running for the next test
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        for (int k = 0; k <= 49; k++) begin
            if (k > 0) step();
            got   = sample_n();
            exp_v = exp_obs(k, 8, 4, M_DN1, 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL abort_rerun k=%0d got=%h exp=%h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        obs_t got;
        obs_t exp_v;
        exp_v = '0;
        // reset low at E50 of the running pass, with abort and start also high
        n_reset = 1'b0;
        n_abort = 1'b1;
        n_start = 1'b1;
        step();
        got = sample_n();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL mid_run_reset got=%h exp=%h", got, exp_v);
        end
        n_reset = 1'b1;
        n_abort = 1'b0;
        n_start = 1'b0;
        step();
        got = sample_n();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL mid_run_reset_idle got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_wide_build();
        obs_t got;
        obs_t exp_v;
        exp_v = '0;
        got   = sample_w();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL wide_idle got=%h exp=%h", got, exp_v);
        end
        w_start = 1'b1;
        step();
        w_start = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            got   = sample_w();
            exp_v = exp_obs(k, 1, 2, 2'b00, 1'b0);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL wide_run k=%0d got=%h exp=%h", k, got, exp_v);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_reset = 1'b0;
        n_start = 1'b0;
        n_abort = 1'b0;
        w_reset = 1'b0;
        w_start = 1'b0;
        w_abort = 1'b0;
        #1;

        test_reset();
        test_default_run();
        test_start_while_busy();
        test_restart_from_done();
        test_abort();
        test_mid_run_reset();
        test_wide_build();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
